// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, FSM state type and pointer helper for the 8-way
// round-robin arbiter.
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        BACKOFF = 2'd2
    } arb_state_e;

    // Priority pointer after serving idx: the slot just after it, wrapping 7 -> 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
//
// Handshake: req[i] is a level request held by requester i for as long as it
// wants the resource. gnt[i] (with gnt_valid and gnt_idx) is the arbiter's
// answer; requester i owns the resource in every cycle gnt[i] is high and
// releases it by dropping req[i]. en only gates the issue of new grants.
// timeout is a one-cycle notice that a grant was taken away while the
// requester was still asking for it.
interface rr_arbiter_8_if;

    logic                       en;
    logic [arb_pkg::NREQ-1:0]   req;
    logic [arb_pkg::NREQ-1:0]   gnt;
    logic [arb_pkg::IDX_W-1:0]  gnt_idx;
    logic                       gnt_valid;
    logic                       timeout;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter_8_pick.sv
// Rotating-priority pick: the first set request at or after ptr, walking
// ptr, ptr+1, ..., 7, 0, ..., ptr-1.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Walk the ring starting at ptr; the first hit wins and later hits are ignored.
    always_comb begin
        logic [IDX_W-1:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered one-hot grant, binary index,
// hold-while-requesting and forced revoke after MAX_HOLD cycles.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter_8_if.slave bus,
    output arb_state_e  state_o
);

    arb_state_e         state_q;
    logic [NREQ-1:0]    gnt_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               gnt_valid_q;
    logic               timeout_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [HOLD_W-1:0]  hold_cnt_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Pointer moves past the current holder whenever its grant ends.
    assign ptr_d      = next_ptr(gnt_idx_q);
    assign hold_cnt_d = hold_cnt_q + HOLD_W'(1);

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (bus.en && pick_any) begin
                        gnt_q       <= NREQ'(1) << pick_idx;
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= HOLD_W'(1);
                        state_q     <= BUSY;
                    end else begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // Release is checked first so a voluntary drop never pulses timeout.
                    if (!bus.req[gnt_idx_q]) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= BACKOFF;
                    end else begin
                        timeout_q   <= 1'b0;
                        hold_cnt_q  <= hold_cnt_d;
                    end
                end
                BACKOFF: begin
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: scenario tasks push expected
// {gnt_valid, timeout, gnt, gnt_idx} words and compare them against the DUT.
module tb_rr_arbiter_8;
    import arb_pkg::*;

    logic        clk;
    logic        rst_n;
    arb_state_e  state_dbg;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    logic [12:0] exp_q[$];
    int          checks;
    int          fails;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [12:0] mk(input logic v, input logic t, input int idx);
        logic [7:0] g;
        g = v ? (8'h01 << idx) : 8'h00;
        return {v, t, g, 3'(idx)};
    endfunction

    function automatic logic [12:0] observe();
        return {bus.gnt_valid, bus.timeout, bus.gnt, bus.gnt_idx};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [12:0] exp, got;
        for (int s = 0; s < 7; s++) begin
            case (s)
                0: begin
                    rst_n = 1'b0; bus.en = 1'b0; bus.req = 8'h00;
                    repeat (2) @(posedge clk);
                    #1;
                    exp_q.push_back(mk(0, 0, 0));
                end
                1: begin
                    rst_n = 1'b1; bus.en = 1'b1; bus.req = 8'h08;
                    exp_q.push_back(mk(1, 0, 3));
                    tick();
                end
                2: begin
                    bus.req = 8'h00;
                    exp_q.push_back(mk(0, 0, 0));
                    tick();
                end
                3: begin
                    bus.req = 8'h10;
                    exp_q.push_back(mk(1, 0, 4));
                    tick();
                end
                4: begin
                    rst_n = 1'b0; bus.req = 8'h81;
                    exp_q.push_back(mk(0, 0, 0));
                    #2;
                end
                5: begin
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    exp_q.push_back(mk(1, 0, 0));
                    tick();
                end
                default: begin
                    bus.req = 8'h00;
                    exp_q.push_back(mk(0, 0, 0));
                    tick();
                end
            endcase
            got = observe();
            exp = exp_q.pop_front();
            if (!exp[12]) got[2:0] = exp[2:0];
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL reset step %0d: got %h expected %h", s, got, exp);
            end
            if (s == 0 || s == 4) begin
                checks++;
                if (state_dbg !== IDLE) begin
                    fails++;
                    $display("FAIL reset state step %0d: got %0d expected %0d", s, state_dbg, IDLE);
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic [12:0] exp, got;
        int          hold;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            hold = $urandom_range(1, 4);
            for (int h = 0; h <= hold; h++) begin
                if (h == hold) begin
                    bus.req = 8'hFF & ~(8'h01 << (k % 8));
                    exp_q.push_back(mk(0, 0, 0));
                end else begin
                    exp_q.push_back(mk(1, 0, k % 8));
                end
                tick();
                got = observe();
                exp = exp_q.pop_front();
                if (!exp[12]) got[2:0] = exp[2:0];
                checks++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL rotation grant %0d cyc %0d: got %h expected %h", k, h, got, exp);
                end
                bus.req = 8'hFF;
            end
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        logic [12:0] exp, got;
        logic [7:0]  req_tab[4];
        logic [12:0] exp_tab[4];
        req_tab = '{8'h20, 8'h00, 8'h21, 8'h00};
        exp_tab = '{mk(1, 0, 5), mk(0, 0, 0), mk(1, 0, 0), mk(0, 0, 0)};
        do_reset();
        bus.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.req = req_tab[s];
            exp_q.push_back(exp_tab[s]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            if (!exp[12]) got[2:0] = exp[2:0];
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL wrap step %0d: got %h expected %h", s, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [12:0] exp, got;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h04;
        for (int c = 0; c < 20; c++) begin
            if (c < 16)       exp_q.push_back(mk(1, 0, 2));
            else if (c == 16) exp_q.push_back(mk(0, 1, 0));
            else if (c == 17) exp_q.push_back(mk(0, 0, 0));
            else if (c == 18) exp_q.push_back(mk(1, 0, 2));
            else begin
                bus.req = 8'h00;
                exp_q.push_back(mk(0, 0, 0));
            end
            tick();
            got = observe();
            exp = exp_q.pop_front();
            if (!exp[12]) got[2:0] = exp[2:0];
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL timeout cyc %0d: got %h expected %h", c, got, exp);
            end
            if (c == 16) begin
                checks++;
                if (state_dbg !== BACKOFF) begin
                    fails++;
                    $display("FAIL timeout backoff state: got %0d expected %0d", state_dbg, BACKOFF);
                end
            end
        end
    endtask

    task automatic test_en_gating();
        logic [12:0] exp, got;
        logic        en_tab[10];
        logic [7:0]  req_tab[10];
        logic [12:0] exp_tab[10];
        en_tab  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        req_tab = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h00};
        exp_tab = '{mk(0, 0, 0), mk(0, 0, 0), mk(1, 0, 4), mk(1, 0, 4), mk(1, 0, 4),
                    mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(1, 0, 4), mk(0, 0, 0)};
        do_reset();
        for (int s = 0; s < 10; s++) begin
            bus.en  = en_tab[s];
            bus.req = req_tab[s];
            exp_q.push_back(exp_tab[s]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            if (!exp[12]) got[2:0] = exp[2:0];
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL en_gating step %0d: got %h expected %h", s, got, exp);
            end
        end
    endtask

    task automatic test_tie();
        logic [12:0] exp, got;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h02;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                exp_q.push_back(mk(1, 0, 1));
            end else begin
                bus.req = 8'h00;
                exp_q.push_back(mk(0, 0, 0));
            end
            tick();
            got = observe();
            exp = exp_q.pop_front();
            if (!exp[12]) got[2:0] = exp[2:0];
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL tie cyc %0d: got %h expected %h", c, got, exp);
            end
            if (c == 16) begin
                checks++;
                if (state_dbg !== IDLE) begin
                    fails++;
                    $display("FAIL tie state: got %0d expected %0d", state_dbg, IDLE);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks  = 0;
        fails   = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_en_gating();
        test_tie();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
